// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the single-port unified RAM to either the instruction
// fetch or the data requester, one access at a time, with data priority and
// a starvation limit that eventually forces an instruction grant.
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              RST,
    // instruction requester
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] iload,
    output logic              ihit,
    // data requester
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic [DATA_W-1:0] dload,
    output logic              dhit,
    // RAM side
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_store,
    input  logic [DATA_W-1:0] ram_load,
    input  logic              ram_ready
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             dreq;
    logic             starve_hit;

    assign dreq       = dREN | dWEN;
    assign starve_hit = iREN && (starve_cnt_q == CNT_MAX);

    // Next-state and starvation-counter logic; a dropped request aborts the grant.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        case (state_q)
            IDLE: begin
                if (dreq && !starve_hit) begin
                    state_d = DGRANT;
                    if (!iREN) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt_q >= CNT_MAX) begin
                        starve_cnt_d = CNT_MAX;
                    end else begin
                        starve_cnt_d = starve_cnt_q + CNT_W'(1);
                    end
                end else if (iREN) begin
                    state_d      = IGRANT;
                    starve_cnt_d = '0;
                end
            end
            IGRANT: begin
                if (!iREN || ram_ready) state_d = IDLE;
            end
            DGRANT: begin
                if (!dreq || ram_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // RAM strobes and hit pulses follow the live request of the granted side.
    always_comb begin
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_store = '0;
        ihit      = 1'b0;
        iload     = '0;
        dhit      = 1'b0;
        dload     = '0;
        case (state_q)
            IGRANT: begin
                if (iREN) begin
                    ram_ren  = 1'b1;
                    ram_addr = iaddr;
                    if (ram_ready && !RST) begin
                        ihit  = 1'b1;
                        iload = ram_load;
                    end
                end
            end
            DGRANT: begin
                if (dreq) begin
                    ram_addr = daddr;
                    if (dWEN) begin
                        ram_wen   = 1'b1;
                        ram_store = dstore;
                    end else begin
                        ram_ren = 1'b1;
                    end
                    if (ram_ready && !RST) begin
                        dhit = 1'b1;
                        if (!dWEN) dload = ram_load;
                    end
                end
            end
            default: ;
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic, all checked
// against a transaction-level model of who owns the RAM this cycle.
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SM = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          iREN, dREN, dWEN, ram_ready;
    logic [AW-1:0] iaddr, daddr, ram_addr;
    logic [DW-1:0] dstore, ram_load, iload, dload, ram_store;
    logic          ihit, dhit, ram_ren, ram_wen;

    int n_vec = 0;
    int n_err = 0;

    // model: 0 = nobody owns the RAM, 1 = instruction side, 2 = data side
    int   m_owner = 0;
    int   m_cnt   = 0;
    logic m_ihit  = 1'b0;
    logic m_dhit  = 1'b0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dhit(dhit),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_store(ram_store), .ram_load(ram_load), .ram_ready(ram_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Compare every output against the model, then advance model and clock.
    task automatic step();
        logic          live, e_ren, e_wen, e_ih, e_dh;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_st, e_il, e_dl;
        #2;
        e_ren = 0; e_wen = 0; e_ih = 0; e_dh = 0;
        e_addr = '0; e_st = '0; e_il = '0; e_dl = '0;
        live = (m_owner == 1) ? iREN : (m_owner == 2) ? (dREN | dWEN) : 1'b0;
        if (m_owner == 1 && live) begin
            e_ren  = 1;
            e_addr = iaddr;
            e_ih   = ram_ready && !RST;
            if (e_ih) e_il = ram_load;
        end
        if (m_owner == 2 && live) begin
            e_addr = daddr;
            if (dWEN) begin
                e_wen = 1;
                e_st  = dstore;
            end else begin
                e_ren = 1;
            end
            e_dh = ram_ready && !RST;
            if (e_dh && !dWEN) e_dl = ram_load;
        end
        chk("ram_ren", 64'(ram_ren), 64'(e_ren));
        chk("ram_wen", 64'(ram_wen), 64'(e_wen));
        chk("ram_addr", 64'(ram_addr), 64'(e_addr));
        chk("ram_store", 64'(ram_store), 64'(e_st));
        chk("ihit", 64'(ihit), 64'(e_ih));
        chk("iload", 64'(iload), 64'(e_il));
        chk("dhit", 64'(dhit), 64'(e_dh));
        chk("dload", 64'(dload), 64'(e_dl));
        m_ihit = e_ih;
        m_dhit = e_dh;
        if (RST) begin
            m_owner = 0;
            m_cnt   = 0;
        end else if (m_owner == 0) begin
            if ((dREN || dWEN) && !(iREN && m_cnt == SM)) begin
                m_owner = 2;
                m_cnt   = iREN ? ((m_cnt + 1 > SM) ? SM : m_cnt + 1) : 0;
            end else if (iREN) begin
                m_owner = 1;
                m_cnt   = 0;
            end
        end else if (!live || ram_ready) begin
            m_owner = 0;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
        iaddr = '0; daddr = '0; dstore = '0; ram_load = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RST = 1;
        step();
        RST = 0;
    endtask

    initial begin
        logic [39:0] order;
        logic [39:0] order_exp;
        int          nh;

        RST = 1;
        idle_inputs();
        @(posedge CLK);
        #1;
        m_owner = 0;
        m_cnt   = 0;
        // reset state: everything quiet
        #1;
        chk("rst_ren", 64'(ram_ren), 64'(0));
        chk("rst_addr", 64'(ram_addr), 64'(0));
        step();
        RST = 0;

        // single fetch with ram_ready always high
        iREN = 1; iaddr = 32'h40; ram_ready = 1; ram_load = 32'h2408_0005;
        step();
        #1;
        chk("f1_ren", 64'(ram_ren), 64'(1));
        chk("f1_addr", 64'(ram_addr), 64'h40);
        chk("f1_ihit", 64'(ihit), 64'(1));
        chk("f1_iload", 64'(iload), 64'h2408_0005);
        step();
        #1;
        chk("f2_bubble", 64'(ihit), 64'(0));
        step();
        #1;
        chk("f3_regrant", 64'(ram_ren), 64'(1));
        step();

        // starvation: both sides hold requests, grant order D,D,D,D,I
        do_reset();
        iREN = 1; iaddr = 32'h80; dREN = 1; daddr = 32'h100; ram_ready = 1;
        order = '0;
        nh = 0;
        for (int c = 0; c < 12 && nh < 5; c++) begin
            #1;
            if (dhit) begin order = {order[31:0], 8'h44}; nh++; end
            if (ihit) begin order = {order[31:0], 8'h49}; nh++; end
            step();
        end
        order_exp = "DDDDI";
        chk("starve_order", 64'(order), 64'(order_exp));

        // write wins over read, ready after 3 cycles
        do_reset();
        dWEN = 1; dREN = 1; daddr = 32'h200; dstore = 32'hDEAD_BEEF; ram_load = 32'h1234_5678;
        step();
        for (int c = 1; c <= 3; c++) begin
            #1;
            chk("w_wen", 64'(ram_wen), 64'(1));
            chk("w_ren", 64'(ram_ren), 64'(0));
            chk("w_store", 64'(ram_store), 64'hDEAD_BEEF);
            step();
        end
        ram_ready = 1;
        #1;
        chk("w_dhit", 64'(dhit), 64'(1));
        chk("w_dload", 64'(dload), 64'(0));
        step();
        idle_inputs();
        step();

        // fetch aborted before ready, pending data read follows
        do_reset();
        iREN = 1; iaddr = 32'h44;
        step();
        dREN = 1; daddr = 32'h300;
        step();
        iREN = 0;
        #1;
        chk("ab_ren", 64'(ram_ren), 64'(0));
        chk("ab_ihit", 64'(ihit), 64'(0));
        step();
        #1;
        chk("ab_idle", 64'(ram_ren), 64'(0));
        step();
        #1;
        chk("ab_dgrant", 64'(ram_ren), 64'(1));
        chk("ab_daddr", 64'(ram_addr), 64'h300);
        step();
        idle_inputs();
        step();

        // reset in the middle of a data grant
        do_reset();
        dREN = 1; daddr = 32'h400;
        step();
        step();
        RST = 1;
        step();
        RST = 0;
        #1;
        chk("mr_ren", 64'(ram_ren), 64'(0));
        chk("mr_addr", 64'(ram_addr), 64'(0));
        step();
        #1;
        chk("mr_regrant", 64'(ram_ren), 64'(1));
        step();

        // ram_ready while idle is ignored
        idle_inputs();
        step();
        ram_ready = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("idle_ihit", 64'(ihit), 64'(0));
            chk("idle_dhit", 64'(dhit), 64'(0));
            step();
        end

        // randomized traffic honouring the hold-until-hit protocol, with aborts and resets
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (m_ihit || !iREN) begin
                iREN  = ($urandom_range(0, 2) == 0);
                iaddr = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                iREN = 0;
            end
            if (m_dhit || !(dREN || dWEN)) begin
                dREN   = ($urandom_range(0, 2) == 0);
                dWEN   = ($urandom_range(0, 3) == 0);
                daddr  = $urandom;
                dstore = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                dREN = 0;
                dWEN = 0;
            end
            ram_ready = ($urandom_range(0, 1) == 1);
            ram_load  = $urandom;
            RST       = ($urandom_range(0, 59) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
